// File: rtl/gpu_pkg.sv
// Shared drawing-pipeline definitions: instruction width, field positions and the
// packed instruction type used between the host interface and the decoder.
package gpu_pkg;

  localparam int INST_W = 82;

  // Field LSB positions inside a packed instruction
  localparam int INST_TYPE_B = 0;
  localparam int VERT_B      = 1;
  localparam int COORD_LSB   = 2;
  localparam int COORD_W     = 16;
  localparam int LAYER_B     = 50;
  localparam int FILL_B      = 51;
  localparam int COLOR_LSB   = 52;
  localparam int COLOR_W     = 24;
  localparam int TEX_LSB     = 76;
  localparam int TEX_W       = 2;
  localparam int ALPHA_LSB   = 78;
  localparam int ALPHA_W     = 4;

  typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer register; advances by one when enabled and wraps
// naturally because DEPTH is a power of two.
module fifo_ptr #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + AW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/inst_fifo.sv
// First-word-fall-through instruction buffer feeding the decode stage, with
// sticky overflow/underflow flags for the host status register.
module inst_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [INST_W-1:0]      wr_data,
  input  logic                   rd_en,
  input  logic                   clear_err,
  output logic [INST_W-1:0]      fifo_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  inst_t         mem [DEPTH];
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;
  logic [AW-1:0] w_wptr;
  logic [AW-1:0] w_rptr;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;

  // Occupancy alone decides full/empty; equal pointers are ambiguous.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;

  fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_wr_acc),
    .o_ptr (w_wptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rptr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_rd_acc),
    .o_ptr (w_rptr)
  );

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      mem[w_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      r_count <= r_count + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      r_count <= r_count - CW'(1);
    end
  end

  // A new error in the same cycle as clear_err takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (clear_err) begin
        r_overflow <= 1'b0;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (clear_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign fifo_data = w_empty ? '0 : mem[w_rptr];
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_inst_fifo.sv
// Randomised and directed checks of inst_fifo against a queue-based model.
module tb_inst_fifo;
  import gpu_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  inst_t       wr_data = '0;
  logic        rd_en = 1'b0;
  logic        clear_err = 1'b0;
  inst_t       fifo_data;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int    n_checks = 0;
  int    n_passed = 0;
  inst_t model_q[$];
  logic  m_ov = 1'b0;
  logic  m_un = 1'b0;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .clear_err (clear_err),
    .fifo_data (fifo_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [INST_W-1:0] obs, input logic [INST_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic inst_t rand_inst();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[INST_W-1:0];
  endfunction

  task automatic check_all(input string tag);
    inst_t exp_data;
    exp_data = (model_q.size() == 0) ? '0 : model_q[0];
    check({tag, ".count"}, INST_W'(count), INST_W'(model_q.size()));
    check({tag, ".empty"}, INST_W'(empty), INST_W'(model_q.size() == 0));
    check({tag, ".full"},  INST_W'(full),  INST_W'(model_q.size() == DEPTH));
    check({tag, ".data"},  fifo_data, exp_data);
    check({tag, ".ovf"},   INST_W'(overflow),  INST_W'(m_ov));
    check({tag, ".unf"},   INST_W'(underflow), INST_W'(m_un));
  endtask

  // One clock of stimulus; the model applies the accept rules to its pre-edge state.
  task automatic step(input string tag, input logic wr, input inst_t wd, input logic rd, input logic clr);
    int  sz;
    logic wacc, racc;
    @(negedge clk);
    wr_en = wr; wr_data = wd; rd_en = rd; clear_err = clr;
    @(posedge clk);
    sz   = model_q.size();
    wacc = wr && (sz < DEPTH);
    racc = rd && (sz > 0);
    if (wr && sz == DEPTH) m_ov = 1'b1; else if (clr) m_ov = 1'b0;
    if (rd && sz == 0)     m_un = 1'b1; else if (clr) m_un = 1'b0;
    if (racc) void'(model_q.pop_front());
    if (wacc) model_q.push_back(wd);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clear_err = 1'b0;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_q.delete(); m_ov = 1'b0; m_un = 1'b0;
    check_all(tag);
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    inst_t w;
    #3;
    check_all("por");
    @(negedge clk); rst = 1'b0;

    // Reset mid-fill, observed before any clock edge
    for (int i = 0; i < 3; i++) step("t1.wr", 1'b1, rand_inst(), 1'b0, 1'b0);
    async_reset("t1.rst");
    step("t1.after", 1'b1, inst_t'(82'h55), 1'b0, 1'b0);
    step("t1.pop", 1'b0, '0, 1'b1, 1'b0);

    // Fill 1..8, overflowing write, drain in order
    for (int i = 1; i <= 8; i++) step("t2.fill", 1'b1, inst_t'(i), 1'b0, 1'b0);
    step("t2.ovf", 1'b1, inst_t'(82'h3FF), 1'b0, 1'b0);
    check("t2.ovf_flag", INST_W'(overflow), INST_W'(1));
    for (int i = 1; i <= 8; i++) begin
      check("t2.order", fifo_data, inst_t'(i));
      step("t2.drain", 1'b0, '0, 1'b1, 1'b0);
    end
    check("t2.empty", INST_W'(empty), INST_W'(1));

    // Underflow then clear
    step("t3.unf", 1'b0, '0, 1'b1, 1'b0);
    check("t3.unf_flag", INST_W'(underflow), INST_W'(1));
    step("t3.clr", 1'b0, '0, 1'b0, 1'b1);
    check("t3.cleared", INST_W'(underflow), INST_W'(0));
    // Set wins over clear
    step("t3.setwin", 1'b0, '0, 1'b1, 1'b1);

    // Steady state at count=4 across pointer wrap
    for (int i = 0; i < 4; i++) step("t4.fill", 1'b1, rand_inst(), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("t4.rw", 1'b1, rand_inst(), 1'b1, 1'b0);
    check("t4.count", INST_W'(count), INST_W'(4));

    // Full with read+write, then empty with read+write
    for (int i = 0; i < 4; i++) step("t5.fill", 1'b1, rand_inst(), 1'b0, 1'b0);
    step("t5.fullrw", 1'b1, rand_inst(), 1'b1, 1'b1);
    check("t5.cnt7", INST_W'(count), INST_W'(7));
    for (int i = 0; i < 7; i++) step("t5.drain", 1'b0, '0, 1'b1, 1'b0);
    w = rand_inst();
    step("t5.emptyrw", 1'b1, w, 1'b1, 1'b1);
    check("t5.cnt1", INST_W'(count), INST_W'(1));
    check("t5.word", fifo_data, w);
    step("t5.pop", 1'b0, '0, 1'b1, 1'b1);

    // Alpha then draw instruction, bit-exact
    w = '0; w[0] = 1'b1; w[3:1] = 3'b101;
    step("t6.alpha", 1'b1, w, 1'b0, 1'b0);
    check("t6.alpha_word", fifo_data, w);
    w = rand_inst(); w[0] = 1'b0;
    step("t6.draw", 1'b1, w, 1'b0, 1'b0);
    step("t6.pop1", 1'b0, '0, 1'b1, 1'b0);
    check("t6.draw_word", fifo_data, w);
    step("t6.pop2", 1'b0, '0, 1'b1, 1'b0);

    // Random traffic with an occasional reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset("rnd.rst");
      step("rnd", 1'($urandom_range(0, 99) < 55), rand_inst(),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
